// File: rtl/gelato_register_bank_arbiter_pkg.sv
// Shared widths and the per-bank command record for the register bank arbiter.
// Machine-wide sizing macros default here when no global defines file provides them.
`ifndef WARP_NUM
`define WARP_NUM 8
`endif
`ifndef THREAD_NUM
`define THREAD_NUM 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package gelato_register_bank_arbiter_pkg;

  localparam int THREAD_NUM   = `THREAD_NUM;
  localparam int WARP_ID_W    = $clog2(`WARP_NUM);
  localparam int REG_ID_W     = 6;
  localparam int WARP_REG_W   = `THREAD_NUM * `DATA_WIDTH;
  localparam int BANK_NUM_DEF = 4;
  localparam int BANK_SEL_W   = $clog2(BANK_NUM_DEF);

  typedef struct packed {
    logic                  write;
    logic [WARP_ID_W-1:0]  warp;
    logic [REG_ID_W-1:0]   reg_id;
    logic [THREAD_NUM-1:0] mask;
    logic [WARP_REG_W-1:0] data;
  } bank_cmd_t;

endpackage

// File: rtl/gelato_register_bank_arbiter_if.sv
// Operand-read, writeback and register-bank signal bundle.
// master = collectors/writeback/banks side, slave = the arbiter.
interface gelato_register_bank_arbiter_if
  import gelato_register_bank_arbiter_pkg::*;
#(
  parameter int BANK_NUM = 4,
  parameter int REQ_NUM  = 4
);

  logic [REQ_NUM-1:0]             rd_req_valid;
  logic [REQ_NUM-1:0]             rd_req_ready;
  logic [REQ_NUM*WARP_ID_W-1:0]   rd_req_warp;
  logic [REQ_NUM*REG_ID_W-1:0]    rd_req_reg;
  logic [REQ_NUM-1:0]             rd_rsp_valid;
  logic [REQ_NUM*WARP_REG_W-1:0]  rd_rsp_data;

  logic                           wr_req_valid;
  logic                           wr_req_ready;
  logic [WARP_ID_W-1:0]           wr_req_warp;
  logic [REG_ID_W-1:0]            wr_req_reg;
  logic [THREAD_NUM-1:0]          wr_req_mask;
  logic [WARP_REG_W-1:0]          wr_req_data;

  logic [BANK_NUM-1:0]            bank_write;
  logic [BANK_NUM*WARP_ID_W-1:0]  bank_warp;
  logic [BANK_NUM*REG_ID_W-1:0]   bank_reg;
  logic [BANK_NUM*THREAD_NUM-1:0] bank_mask;
  logic [BANK_NUM*WARP_REG_W-1:0] bank_wdata;
  logic [BANK_NUM*WARP_REG_W-1:0] bank_rdata;

  modport master (
    output rd_req_valid, rd_req_warp, rd_req_reg,
    output wr_req_valid, wr_req_warp, wr_req_reg, wr_req_mask, wr_req_data,
    output bank_rdata,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready,
    input  bank_write, bank_warp, bank_reg, bank_mask, bank_wdata
  );

  modport slave (
    input  rd_req_valid, rd_req_warp, rd_req_reg,
    input  wr_req_valid, wr_req_warp, wr_req_reg, wr_req_mask, wr_req_data,
    input  bank_rdata,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready,
    output bank_write, bank_warp, bank_reg, bank_mask, bank_wdata
  );

endinterface

// File: rtl/gelato_register_bank_arbiter_rr.sv
// N-way round-robin picker: first asserted request at or after ptr wins, one-hot grant.
module gelato_rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (sum >= (PTR_W + 1)'(N)) sum = sum - (PTR_W + 1)'(N);
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gelato_register_bank_arbiter.sv
// Per-bank single-port arbitration between REQ_NUM operand reads and one writeback write,
// with write priority bounded by a per-bank starve counter and a one-cycle response path.
module gelato_register_bank_arbiter
  import gelato_register_bank_arbiter_pkg::*;
#(
  parameter int BANK_NUM     = 4,
  parameter int REQ_NUM      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic                          clk,
  input logic                          rst,
  input logic                          rdy,
  gelato_register_bank_arbiter_if.slave bus
);

  localparam int SEL_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                 en;
  logic [WARP_ID_W-1:0] rq_warp [REQ_NUM];
  logic [REG_ID_W-1:0]  rq_reg  [REQ_NUM];
  logic [SEL_W-1:0]     rq_bank [REQ_NUM];
  logic [SEL_W-1:0]     wr_bank;

  logic [REQ_NUM-1:0]   tgt     [BANK_NUM];
  logic [REQ_NUM-1:0]   rd_gnt  [BANK_NUM];
  logic [PTR_W-1:0]     gnt_idx [BANK_NUM];
  logic [BANK_NUM-1:0]  any_rd;
  logic [BANK_NUM-1:0]  wr_take;
  logic [BANK_NUM-1:0]  rd_take;
  logic [REQ_NUM-1:0]   rd_ready;
  bank_cmd_t            cmd     [BANK_NUM];

  logic [PTR_W-1:0]     rr_ptr  [BANK_NUM];
  logic [CNT_W-1:0]     starve  [BANK_NUM];
  bank_cmd_t            held    [BANK_NUM];
  logic [REQ_NUM-1:0]   pend;
  logic [SEL_W-1:0]     pbank   [REQ_NUM];

  // Reset dominates rdy: no grants or responses while rst is high.
  assign en      = rdy & ~rst;
  assign wr_bank = bus.wr_req_reg[SEL_W-1:0];

  always_comb begin
    for (int r = 0; r < REQ_NUM; r++) begin
      rq_warp[r] = bus.rd_req_warp[r*WARP_ID_W +: WARP_ID_W];
      rq_reg[r]  = bus.rd_req_reg[r*REG_ID_W +: REG_ID_W];
      rq_bank[r] = rq_reg[r][SEL_W-1:0];
    end
  end

  always_comb begin
    any_rd  = '0;
    wr_take = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      tgt[b] = '0;
      for (int r = 0; r < REQ_NUM; r++)
        tgt[b][r] = bus.rd_req_valid[r] && (rq_bank[r] == SEL_W'(b));
      any_rd[b]  = |tgt[b];
      wr_take[b] = en && bus.wr_req_valid && (wr_bank == SEL_W'(b)) &&
                   !((starve[b] == CNT_W'(STARVE_LIMIT)) && any_rd[b]);
    end
  end

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    logic [REQ_NUM-1:0] arb_req;
    assign arb_req = (en && !wr_take[b]) ? tgt[b] : '0;
    gelato_rr_arbiter #(.N(REQ_NUM)) u_rr (
      .req   (arb_req),
      .ptr   (rr_ptr[b]),
      .grant (rd_gnt[b])
    );
  end

  always_comb begin
    rd_ready = '0;
    rd_take  = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      gnt_idx[b] = '0;
      rd_take[b] = |rd_gnt[b];
      rd_ready   = rd_ready | rd_gnt[b];
      for (int r = 0; r < REQ_NUM; r++)
        if (rd_gnt[b][r]) gnt_idx[b] = PTR_W'(r);
    end
  end

  // Idle banks re-present the last address as a harmless read.
  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) begin
      cmd[b]       = held[b];
      cmd[b].write = 1'b0;
      if (wr_take[b]) begin
        cmd[b].write  = 1'b1;
        cmd[b].warp   = bus.wr_req_warp;
        cmd[b].reg_id = bus.wr_req_reg;
        cmd[b].mask   = bus.wr_req_mask;
        cmd[b].data   = bus.wr_req_data;
      end else if (rd_take[b]) begin
        cmd[b].warp   = rq_warp[gnt_idx[b]];
        cmd[b].reg_id = rq_reg[gnt_idx[b]];
      end
      if (rst) cmd[b] = '0;
    end
  end

  always_comb begin
    bus.bank_write = '0;
    bus.bank_warp  = '0;
    bus.bank_reg   = '0;
    bus.bank_mask  = '0;
    bus.bank_wdata = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      bus.bank_write[b]                            = cmd[b].write;
      bus.bank_warp[b*WARP_ID_W +: WARP_ID_W]      = cmd[b].warp;
      bus.bank_reg[b*REG_ID_W +: REG_ID_W]         = cmd[b].reg_id;
      bus.bank_mask[b*THREAD_NUM +: THREAD_NUM]    = cmd[b].mask;
      bus.bank_wdata[b*WARP_REG_W +: WARP_REG_W]   = cmd[b].data;
    end
  end

  always_comb begin
    bus.rd_rsp_data = '0;
    for (int r = 0; r < REQ_NUM; r++)
      for (int b = 0; b < BANK_NUM; b++)
        if (pbank[r] == SEL_W'(b))
          bus.rd_rsp_data[r*WARP_REG_W +: WARP_REG_W] = bus.bank_rdata[b*WARP_REG_W +: WARP_REG_W];
  end

  assign bus.rd_req_ready = rd_ready;
  assign bus.wr_req_ready = |wr_take;
  assign bus.rd_rsp_valid = pend & {REQ_NUM{en}};

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      for (int r = 0; r < REQ_NUM; r++) pbank[r] <= '0;
      for (int b = 0; b < BANK_NUM; b++) begin
        rr_ptr[b] <= '0;
        starve[b] <= '0;
        held[b]   <= '0;
      end
    end else if (rdy) begin
      pend <= rd_ready;
      for (int r = 0; r < REQ_NUM; r++)
        if (rd_ready[r]) pbank[r] <= rq_bank[r];
      for (int b = 0; b < BANK_NUM; b++) begin
        held[b] <= cmd[b];
        if (rd_take[b]) begin
          rr_ptr[b] <= (gnt_idx[b] == PTR_W'(REQ_NUM - 1)) ? '0 : gnt_idx[b] + 1'b1;
          starve[b] <= '0;
        end else if (!any_rd[b]) begin
          starve[b] <= '0;
        end else if (wr_take[b] && (starve[b] != CNT_W'(STARVE_LIMIT))) begin
          starve[b] <= starve[b] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gelato_register_bank_arbiter.sv
// Directed bench for the register bank arbiter: per-cycle grant checks plus a
// per-requester response scoreboard fed at grant time and drained by a monitor.
module tb_gelato_register_bank_arbiter;
  import gelato_register_bank_arbiter_pkg::*;

  localparam int BN = 4;
  localparam int RN = 4;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  gelato_register_bank_arbiter_if #(.BANK_NUM(BN), .REQ_NUM(RN)) bus ();

  gelato_register_bank_arbiter #(
    .BANK_NUM(BN), .REQ_NUM(RN), .STARVE_LIMIT(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [WARP_REG_W-1:0] exp_q [RN][$];

  function automatic logic [WARP_REG_W-1:0] hash(int b, int w, int g);
    return WARP_REG_W'({8'(b), 8'(w), 8'(g), 8'hA5});
  endfunction

  // Bank model: registered read of the presented address, frozen while rdy=0.
  always @(posedge clk) begin
    if (rdy)
      for (int b = 0; b < BN; b++)
        if (!bus.bank_write[b])
          bus.bank_rdata[b*WARP_REG_W +: WARP_REG_W] <= hash(b,
            int'(bus.bank_warp[b*WARP_ID_W +: WARP_ID_W]),
            int'(bus.bank_reg[b*REG_ID_W +: REG_ID_W]));
  end

  // Expected response is derived from the requester's own fields when its read is accepted.
  always @(negedge clk) begin
    for (int r = 0; r < RN; r++)
      if (bus.rd_req_valid[r] && bus.rd_req_ready[r]) begin
        int g;
        g = int'(bus.rd_req_reg[r*REG_ID_W +: REG_ID_W]);
        exp_q[r].push_back(hash(g % BN, int'(bus.rd_req_warp[r*WARP_ID_W +: WARP_ID_W]), g));
      end
  end

  always @(negedge clk) begin
    for (int r = 0; r < RN; r++)
      if (bus.rd_rsp_valid[r] === 1'b1) begin
        logic [WARP_REG_W-1:0] got;
        logic [WARP_REG_W-1:0] want;
        got = bus.rd_rsp_data[r*WARP_REG_W +: WARP_REG_W];
        checks++;
        if (exp_q[r].size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected req%0d: got %h, expected no response", r, got);
        end else begin
          want = exp_q[r].pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL rsp_data req%0d: got %h expected %h", r, got, want);
          end
        end
      end
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_rd(int r, logic v, int w, int g);
    bus.rd_req_valid[r]                         = v;
    bus.rd_req_warp[r*WARP_ID_W +: WARP_ID_W]   = WARP_ID_W'(w);
    bus.rd_req_reg[r*REG_ID_W +: REG_ID_W]      = REG_ID_W'(g);
  endtask

  function automatic int bwarp(int b);
    return int'(bus.bank_warp[b*WARP_ID_W +: WARP_ID_W]);
  endfunction

  function automatic int breg(int b);
    return int'(bus.bank_reg[b*REG_ID_W +: REG_ID_W]);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.rd_req_valid = '0;
    bus.rd_req_warp  = '0;
    bus.rd_req_reg   = '0;
    bus.wr_req_valid = 1'b1;
    bus.wr_req_warp  = 3'(1);
    bus.wr_req_reg   = 6'd2;
    bus.wr_req_mask  = '1;
    bus.wr_req_data  = 32'h1234_5678;
    set_rd(0, 1'b1, 1, 1);

    // Reset: requests present but nothing may be granted or driven.
    tick();
    sample();
    chk("rst_rd_ready", 64'(bus.rd_req_ready), 64'h0);
    chk("rst_wr_ready", 64'(bus.wr_req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rd_rsp_valid), 64'h0);
    chk("rst_bank_write", 64'(bus.bank_write), 64'h0);
    chk("rst_bank_reg", 64'(bus.bank_reg), 64'h0);
    tick();
    rst = 1'b0;
    bus.wr_req_valid = 1'b0;
    set_rd(0, 1'b0, 0, 0);
    sample();
    chk("post_rst_bank_warp", 64'(bus.bank_warp), 64'h0);
    chk("post_rst_rsp_valid", 64'(bus.rd_rsp_valid), 64'h0);
    tick();

    // Single read: req0 warp 2 reg 5 -> bank 1.
    set_rd(0, 1'b1, 2, 5);
    sample();
    chk("t1_ready", 64'(bus.rd_req_ready), 64'h1);
    chk("t1_bank1_reg", 64'(breg(1)), 64'd5);
    chk("t1_bank1_warp", 64'(bwarp(1)), 64'd2);
    chk("t1_bank_write", 64'(bus.bank_write), 64'h0);
    tick();
    set_rd(0, 1'b0, 0, 0);
    sample();
    chk("t1_rsp_valid", 64'(bus.rd_rsp_valid), 64'h1);
    chk("t1_idle_ready", 64'(bus.rd_req_ready), 64'h0);
    chk("t1_hold_bank1_reg", 64'(breg(1)), 64'd5);
    tick();
    sample();
    chk("t1_rsp_done", 64'(bus.rd_rsp_valid), 64'h0);
    tick();

    // Round-robin: all four requesters on bank 2.
    for (int r = 0; r < RN; r++) set_rd(r, 1'b1, r, 2 + 4 * r);
    for (int k = 0; k < 5; k++) begin
      sample();
      chk($sformatf("t2_ready_c%0d", k), 64'(bus.rd_req_ready), 64'(1 << (k % 4)));
      chk($sformatf("t2_rsp_c%0d", k), 64'(bus.rd_rsp_valid),
          (k == 0) ? 64'h0 : 64'(1 << ((k - 1) % 4)));
      tick();
    end
    for (int r = 0; r < RN; r++) set_rd(r, 1'b0, 0, 0);
    sample();
    chk("t2_rsp_last", 64'(bus.rd_rsp_valid), 64'h1);
    tick();

    // Parallel banks: req r reads reg r.
    for (int r = 0; r < RN; r++) set_rd(r, 1'b1, r + 4, r);
    sample();
    chk("t3_ready", 64'(bus.rd_req_ready), 64'hF);
    tick();
    for (int r = 0; r < RN; r++) set_rd(r, 1'b0, 0, 0);
    sample();
    chk("t3_rsp", 64'(bus.rd_rsp_valid), 64'hF);
    tick();

    // Write priority with starvation relief on bank 0; req1 reads bank 1 alongside.
    bus.wr_req_valid = 1'b1;
    bus.wr_req_warp  = 3'(3);
    bus.wr_req_reg   = 6'd4;
    bus.wr_req_mask  = 4'b1010;
    bus.wr_req_data  = 32'hDEAD_BEEF;
    set_rd(0, 1'b1, 1, 8);
    set_rd(1, 1'b1, 6, 1);
    for (int k = 0; k < 5; k++) begin
      sample();
      chk($sformatf("t4_wr_ready_c%0d", k), 64'(bus.wr_req_ready), (k == 3) ? 64'h0 : 64'h1);
      chk($sformatf("t4_rd_ready_c%0d", k), 64'(bus.rd_req_ready),
          (k == 0) ? 64'h2 : (k == 3) ? 64'h1 : 64'h0);
      chk($sformatf("t4_bank_write_c%0d", k), 64'(bus.bank_write), (k == 3) ? 64'h0 : 64'h1);
      chk($sformatf("t4_rsp_c%0d", k), 64'(bus.rd_rsp_valid),
          (k == 1) ? 64'h2 : (k == 4) ? 64'h1 : 64'h0);
      if (k == 0) begin
        chk("t4_wdata", 64'(bus.bank_wdata[31:0]), 64'hDEAD_BEEF);
        chk("t4_mask", 64'(bus.bank_mask[3:0]), 64'hA);
        chk("t4_wr_reg", 64'(breg(0)), 64'd4);
      end
      if (k == 3) begin
        chk("t4_rd_reg", 64'(breg(0)), 64'd8);
        chk("t4_rd_warp", 64'(bwarp(0)), 64'd1);
      end
      tick();
      if (k == 0) set_rd(1, 1'b0, 0, 0);
      if (k == 3) set_rd(0, 1'b0, 0, 0);
    end
    bus.wr_req_valid = 1'b0;

    // rdy stall: req2 granted, rdy low two cycles, response re-presented afterwards.
    set_rd(2, 1'b1, 5, 7);
    sample();
    chk("t5_ready_c0", 64'(bus.rd_req_ready), 64'h4);
    tick();
    set_rd(2, 1'b0, 0, 0);
    set_rd(3, 1'b1, 2, 3);
    rdy = 1'b0;
    for (int k = 1; k < 3; k++) begin
      sample();
      chk($sformatf("t5_stall_ready_c%0d", k), 64'(bus.rd_req_ready), 64'h0);
      chk($sformatf("t5_stall_rsp_c%0d", k), 64'(bus.rd_rsp_valid), 64'h0);
      tick();
    end
    rdy = 1'b1;
    sample();
    chk("t5_rsp_c3", 64'(bus.rd_rsp_valid), 64'h4);
    chk("t5_ready_c3", 64'(bus.rd_req_ready), 64'h8);
    tick();
    set_rd(3, 1'b0, 0, 0);
    sample();
    chk("t5_rsp_c4", 64'(bus.rd_rsp_valid), 64'h8);
    tick();

    // Reset mid-flight: req1 granted, then reset drops it and clears rr_ptr.
    set_rd(1, 1'b1, 0, 4);
    sample();
    chk("t6_ready_c0", 64'(bus.rd_req_ready), 64'h2);
    tick();
    set_rd(1, 1'b0, 0, 0);
    set_rd(0, 1'b1, 0, 0);
    set_rd(2, 1'b1, 1, 8);
    rst = 1'b1;
    sample();
    chk("t6_rst_ready", 64'(bus.rd_req_ready), 64'h0);
    chk("t6_rst_rsp", 64'(bus.rd_rsp_valid), 64'h0);
    chk("t6_rst_bank_reg", 64'(bus.bank_reg), 64'h0);
    tick();
    rst = 1'b0;
    exp_q[1].delete();
    sample();
    chk("t6_ready_c2", 64'(bus.rd_req_ready), 64'h1);
    chk("t6_rsp_c2", 64'(bus.rd_rsp_valid), 64'h0);
    tick();
    set_rd(0, 1'b0, 0, 0);
    sample();
    chk("t6_rsp_c3", 64'(bus.rd_rsp_valid), 64'h1);
    chk("t6_ready_c3", 64'(bus.rd_req_ready), 64'h4);
    tick();
    set_rd(2, 1'b0, 0, 0);
    sample();
    chk("t6_rsp_c4", 64'(bus.rd_rsp_valid), 64'h4);
    tick();

    for (int r = 0; r < RN; r++)
      chk($sformatf("drain_req%0d", r), 64'(exp_q[r].size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
